// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB with variable-latency memory handshakes.
// Define IMM_ALU_EN to accept OP-IMM (0010011) instructions; otherwise they trap as illegal.
`timescale 1ns/1ps
module multicycle_control_unit #(
  parameter int ALU_CTRL_W     = 3,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  output logic                  imem_req,
  output logic                  dmem_req,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic                  alu_src,
  output logic                  branch,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [2:0]            state,
  output logic                  instr_retired,
  output logic                  illegal_op,
  output logic                  bus_error
);

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
`ifdef IMM_ALU_EN
  localparam logic [6:0] OP_IMM = 7'b0010011;
`endif

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {CLS_R, CLS_LD, CLS_ST, CLS_BR, CLS_IMM} cls_e;

  state_e                  state_q;
  cls_e                    cls_q;
  logic [TMO_W-1:0]        cnt_q, cnt_d;
  logic                    illegal_q, bus_err_q;
  logic [ALU_CTRL_W-1:0]   alu_q;
  logic                    src_q;
  logic                    wait_ready;

  // Shared R-type / OP-IMM funct decode; SUB only exists for register operands.
  function automatic logic [ALU_CTRL_W-1:0] funct_alu(input logic [2:0] f3,
                                                      input logic [6:0] f7,
                                                      input logic       sub_ok);
    case (f3)
      3'b000:  return (sub_ok && f7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  assign cnt_d      = cnt_q + TMO_W'(1);
  assign wait_ready = (state_q == FETCH) ? imem_ready : dmem_ready;

  // NOTE: every output gets a default first so the partial case arms below cannot infer latches.
  always_comb begin
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src       = 1'b0;
    branch        = 1'b0;
    instr_retired = 1'b0;
    alu_control   = ALU_ADD;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      EXEC: begin
        case (cls_q)
          CLS_R:   alu_control = funct_alu(funct3, funct7, 1'b1);
          CLS_IMM: begin
            alu_src     = 1'b1;
            alu_control = funct_alu(funct3, funct7, 1'b0);
          end
          CLS_BR: begin
            alu_control   = ALU_SUB;
            branch        = 1'b1;
            pc_write      = 1'b1;
            instr_retired = 1'b1;
          end
          default: alu_src = 1'b1;
        endcase
      end
      MEM: begin
        dmem_req  = 1'b1;
        alu_src   = 1'b1;
        mem_read  = (cls_q == CLS_LD);
        mem_write = (cls_q == CLS_ST);
        if (cls_q == CLS_ST && dmem_ready) begin
          pc_write      = 1'b1;
          instr_retired = 1'b1;
        end
      end
      WB: begin
        reg_write     = 1'b1;
        pc_write      = 1'b1;
        instr_retired = 1'b1;
        mem_to_reg    = (cls_q == CLS_LD);
        alu_control   = alu_q;
        alu_src       = src_q;
      end
      default: ;
    endcase
  end

  assign state      = state_q;
  assign illegal_op = illegal_q;
  assign bus_error  = bus_err_q;

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      cls_q     <= CLS_R;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      alu_q     <= ALU_ADD;
      src_q     <= 1'b0;
    end else begin
      case (state_q)
        FETCH, MEM: begin
          if (wait_ready) begin
            cnt_q <= '0;
            if (state_q == FETCH) state_q <= DECODE;
            else                  state_q <= (cls_q == CLS_LD) ? WB : FETCH;
          end else if (cnt_d == TMO_LIMIT) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b1;
            state_q   <= TRAP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DECODE: begin
          state_q <= EXEC;
          case (opcode)
            OP_R:   cls_q <= CLS_R;
            OP_LD:  cls_q <= CLS_LD;
            OP_ST:  cls_q <= CLS_ST;
            OP_BR:  cls_q <= CLS_BR;
`ifdef IMM_ALU_EN
            OP_IMM: cls_q <= CLS_IMM;
`endif
            default: begin
              illegal_q <= 1'b1;
              state_q   <= TRAP;
            end
          endcase
        end
        EXEC: begin
          // WB replays the EXEC operand select and ALU op.
          alu_q <= alu_control;
          src_q <= alu_src;
          case (cls_q)
            CLS_LD, CLS_ST: state_q <= MEM;
            CLS_BR:         state_q <= FETCH;
            default:        state_q <= WB;
          endcase
        end
        WB:      state_q <= FETCH;
        TRAP:    state_q <= TRAP;
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule
